// File: rtl/seq_mul_4bit.sv
// 4x4 unsigned shift-add multiplier: one partial-sum add per cycle, result after four iterations.
// adder_4bit is the shared 4-bit ripple adder used for the partial sums.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       cy
);

  assign {cy, sum} = {1'b0, a} + {1'b0, b};

endmodule

module seq_mul_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [3:0] m;
  logic [3:0] q;
  logic [3:0] acc;
  logic       c;
  logic [1:0] cnt;

  logic [3:0] add_sum;
  logic       add_cy;
  logic [4:0] psum;

  adder_4bit u_add (
    .a   (acc),
    .b   (m),
    .sum (add_sum),
    .cy  (add_cy)
  );

  // c is always zero entering an iteration, so the skip path is just A zero-extended
  assign psum = q[0] ? {add_cy, add_sum} : {c, acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          // add-then-shift of {C,A,Q}: sum bits move down, zero enters C
          {c, acc, q} <= {1'b0, psum, q[3:1]};
          cnt         <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {psum, q[3:1]};
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
